// File: rtl/alsu_pkg.sv
// alsu_pkg: shared types and constants for the ALSU host driver.
//   - opcode_e     : ALSU opcode encoding (6 and 7 are invalid opcodes)
//   - alsu_req_t   : one request, i.e. everything that lands on the ALSU pins
//   - alsu_rsp_t   : one captured response as stored in the response FIFO
//   - stage_t      : in-flight tag carried from accept to capture
//   - ALSU_LAT     : ALSU pin-to-out latency (input regs + output reg)
//   - CAPTURE_STAGES: edges from accept to capture (pins register + ALSU_LAT)
package alsu_pkg;

  localparam int ALSU_LAT       = 2;
  localparam int CAPTURE_STAGES = ALSU_LAT + 1;
  localparam int SEQ_W          = 4;

  typedef enum logic [2:0] {
    OP_OR     = 3'd0,
    OP_XOR    = 3'd1,
    OP_ADD    = 3'd2,
    OP_MULT   = 3'd3,
    OP_SHIFT  = 3'd4,
    OP_ROTATE = 3'd5,
    OP_INV6   = 3'd6,
    OP_INV7   = 3'd7
  } opcode_e;

  typedef struct packed {
    opcode_e           opcode;
    logic signed [2:0] a;
    logic signed [2:0] b;
    logic              cin;
    logic              serial_in;
    logic              direction;
    logic              red_op_a;
    logic              red_op_b;
    logic              bypass_a;
    logic              bypass_b;
  } alsu_req_t;

  typedef struct packed {
    logic signed [5:0] out;
    logic [15:0]       leds;
    logic              invalid;
    logic [SEQ_W-1:0]  seq;
  } alsu_rsp_t;

  localparam int RSP_W = $bits(alsu_rsp_t);

  typedef struct packed {
    logic             vld;
    logic             invalid;
    logic [SEQ_W-1:0] seq;
  } stage_t;

  // Reduction ops are only legal for OR/XOR; opcodes 6/7 are always invalid.
  // Bypass does not mask the flag: the request itself was malformed.
  function automatic logic predict_invalid(input alsu_req_t r);
    return ((r.red_op_a | r.red_op_b) & (r.opcode[1] | r.opcode[2])) |
           (r.opcode[1] & r.opcode[2]);
  endfunction

endpackage

// File: rtl/alsu_host_if.sv
// alsu_host_if: request and response handshakes between control logic and
// the ALSU host.
//   master : the control side (drives requests, consumes responses)
//   slave  : alsu_host (accepts requests, produces responses)
interface alsu_host_if;
  import alsu_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic [2:0]        req_opcode;
  logic signed [2:0] req_A;
  logic signed [2:0] req_B;
  logic              req_cin;
  logic              req_serial_in;
  logic              req_direction;
  logic              req_red_op_A;
  logic              req_red_op_B;
  logic              req_bypass_A;
  logic              req_bypass_B;

  logic              rsp_valid;
  logic              rsp_ready;
  logic signed [5:0] rsp_out;
  logic [15:0]       rsp_leds;
  logic              rsp_invalid;
  logic [SEQ_W-1:0]  rsp_seq;

  modport master (
    output req_valid, req_opcode, req_A, req_B, req_cin, req_serial_in,
           req_direction, req_red_op_A, req_red_op_B, req_bypass_A,
           req_bypass_B, rsp_ready,
    input  req_ready, rsp_valid, rsp_out, rsp_leds, rsp_invalid, rsp_seq
  );

  modport slave (
    input  req_valid, req_opcode, req_A, req_B, req_cin, req_serial_in,
           req_direction, req_red_op_A, req_red_op_B, req_bypass_A,
           req_bypass_B, rsp_ready,
    output req_ready, rsp_valid, rsp_out, rsp_leds, rsp_invalid, rsp_seq
  );

endinterface

// File: rtl/alsu_rsp_fifo.sv
// alsu_rsp_fifo: synchronous response FIFO.
//   clk, rst      : clock, synchronous active-high reset
//   push/push_data: write one entry (dropped only if full and not popping)
//   pop/pop_data  : head entry; pop_data reads as zero while empty
//   count         : number of stored entries
//   empty, full   : status flags
module alsu_rsp_fifo
  import alsu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = RSP_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       pop_data,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty,
  output logic                   full
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             do_push_s, do_pop_s;

  // Next-state for storage, pointers and occupancy.
  always_comb begin
    empty     = (count_q == '0);
    full      = (count_q == FULL_CNT);
    do_pop_s  = pop & ~empty;
    do_push_s = push & (~full | do_pop_s);

    mem_d = mem_q;
    if (do_push_s) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (do_pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    // Simultaneous push and pop leave the occupancy unchanged.
    case ({do_push_s, do_pop_s})
      2'b10:   count_d = count_q + (PTR_W + 1)'(1);
      2'b01:   count_d = count_q - (PTR_W + 1)'(1);
      default: count_d = count_q;
    endcase

    if (empty) begin
      pop_data = '0;
    end else begin
      pop_data = mem_q[rd_ptr_q];
    end
    count = count_q;
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage; contents are don't-care until written, so no reset is needed.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/alsu_host.sv
// alsu_host: initiator-side driver for the ALSU.
//   clk, rst       : clock, synchronous active-high reset
//   bus (slave)    : request valid/ready in, tagged response valid/ready out
//   alsu_* outputs : registered ALSU pin drives, loaded on each accept
//   alsu_out/leds  : ALSU result, captured CAPTURE_STAGES edges after accept
// Responses are returned in order through a RSP_DEPTH-entry FIFO; issue is
// credit-limited so that every in-flight request has a guaranteed FIFO slot.
module alsu_host
  import alsu_pkg::*;
#(
  parameter int RSP_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  alsu_host_if.slave        bus,
  output logic signed [2:0] alsu_A,
  output logic signed [2:0] alsu_B,
  output logic [2:0]        alsu_opcode,
  output logic              alsu_cin,
  output logic              alsu_serial_in,
  output logic              alsu_direction,
  output logic              alsu_red_op_A,
  output logic              alsu_red_op_B,
  output logic              alsu_bypass_A,
  output logic              alsu_bypass_B,
  input  logic signed [5:0] alsu_out,
  input  logic [15:0]       alsu_leds
);

  localparam int CNT_W = $clog2(RSP_DEPTH) + 1;
  localparam logic [CNT_W:0] CRED_MAX = (CNT_W + 1)'(RSP_DEPTH);

  alsu_req_t        req_s, pins_q, pins_d;
  stage_t           stg_q [CAPTURE_STAGES];
  stage_t           stg_d [CAPTURE_STAGES];
  logic [SEQ_W-1:0] seq_q, seq_d;
  logic [CNT_W-1:0] fifo_count_s;
  logic [CNT_W:0]   inflight_s, credit_used_s;
  logic             req_ready_s, accept_s, push_s, pop_s, empty_s, full_s;
  alsu_rsp_t        push_data_s, pop_data_s;

  // Issue decision, pin/sequence next state and the in-flight tag pipeline.
  always_comb begin
    req_s = '{opcode:    opcode_e'(bus.req_opcode),
              a:         bus.req_A,
              b:         bus.req_B,
              cin:       bus.req_cin,
              serial_in: bus.req_serial_in,
              direction: bus.req_direction,
              red_op_a:  bus.req_red_op_A,
              red_op_b:  bus.req_red_op_B,
              bypass_a:  bus.req_bypass_A,
              bypass_b:  bus.req_bypass_B};

    // Credits come from registered state only, so rsp_ready never reaches
    // req_ready combinationally; a same-edge pop frees its credit next cycle.
    inflight_s = '0;
    for (int i = 0; i < CAPTURE_STAGES; i++) begin
      inflight_s = inflight_s + {{CNT_W{1'b0}}, stg_q[i].vld};
    end
    credit_used_s = inflight_s + {1'b0, fifo_count_s};
    req_ready_s   = ~full_s & (credit_used_s < CRED_MAX);
    accept_s      = bus.req_valid & req_ready_s;

    // Pins hold between accepts; SHIFT/ROTATE keep evolving in the ALSU, but
    // only the tagged capture edge is ever reported.
    if (accept_s) begin
      pins_d = req_s;
      seq_d  = seq_q + SEQ_W'(1);
    end else begin
      pins_d = pins_q;
      seq_d  = seq_q;
    end

    stg_d[0] = '{vld: accept_s, invalid: predict_invalid(req_s), seq: seq_q};
    for (int i = 1; i < CAPTURE_STAGES; i++) begin
      stg_d[i] = stg_q[i-1];
    end

    push_s      = stg_q[CAPTURE_STAGES-1].vld;
    push_data_s = '{out:     alsu_out,
                    leds:    alsu_leds,
                    invalid: stg_q[CAPTURE_STAGES-1].invalid,
                    seq:     stg_q[CAPTURE_STAGES-1].seq};
    pop_s       = ~empty_s & bus.rsp_ready;
  end

  // Pin, sequence and in-flight registers; reset discards in-flight requests.
  always_ff @(posedge clk) begin
    if (rst) begin
      pins_q <= '0;
      seq_q  <= '0;
      for (int i = 0; i < CAPTURE_STAGES; i++) begin
        stg_q[i] <= '0;
      end
    end else begin
      pins_q <= pins_d;
      seq_q  <= seq_d;
      stg_q  <= stg_d;
    end
  end

  alsu_rsp_fifo #(
    .DEPTH (RSP_DEPTH),
    .WIDTH (RSP_W)
  ) u_rsp_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push_s),
    .push_data (push_data_s),
    .pop       (pop_s),
    .pop_data  (pop_data_s),
    .count     (fifo_count_s),
    .empty     (empty_s),
    .full      (full_s)
  );

  assign alsu_A          = pins_q.a;
  assign alsu_B          = pins_q.b;
  assign alsu_opcode     = pins_q.opcode;
  assign alsu_cin        = pins_q.cin;
  assign alsu_serial_in  = pins_q.serial_in;
  assign alsu_direction  = pins_q.direction;
  assign alsu_red_op_A   = pins_q.red_op_a;
  assign alsu_red_op_B   = pins_q.red_op_b;
  assign alsu_bypass_A   = pins_q.bypass_a;
  assign alsu_bypass_B   = pins_q.bypass_b;

  assign bus.req_ready   = req_ready_s;
  assign bus.rsp_valid   = ~empty_s;
  assign bus.rsp_out     = pop_data_s.out;
  assign bus.rsp_leds    = pop_data_s.leds;
  assign bus.rsp_invalid = pop_data_s.invalid;
  assign bus.rsp_seq     = pop_data_s.seq;

endmodule

// File: tb/tb_alsu_host.sv
// tb_alsu_host: directed, table-driven bench for alsu_host with a small
// behavioural ALSU (input registers, then registered out/leds) on the pins.
module tb_alsu_host;
  import alsu_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alsu_host_if bus();

  logic signed [2:0] alsu_A, alsu_B;
  logic [2:0]        alsu_opcode;
  logic              alsu_cin, alsu_serial_in, alsu_direction;
  logic              alsu_red_op_A, alsu_red_op_B, alsu_bypass_A, alsu_bypass_B;
  logic signed [5:0] alsu_out;
  logic [15:0]       alsu_leds;

  alsu_host #(.RSP_DEPTH(4)) dut (
    .clk            (clk),
    .rst            (rst),
    .bus            (bus),
    .alsu_A         (alsu_A),
    .alsu_B         (alsu_B),
    .alsu_opcode    (alsu_opcode),
    .alsu_cin       (alsu_cin),
    .alsu_serial_in (alsu_serial_in),
    .alsu_direction (alsu_direction),
    .alsu_red_op_A  (alsu_red_op_A),
    .alsu_red_op_B  (alsu_red_op_B),
    .alsu_bypass_A  (alsu_bypass_A),
    .alsu_bypass_B  (alsu_bypass_B),
    .alsu_out       (alsu_out),
    .alsu_leds      (alsu_leds)
  );

  // ---------------- behavioural ALSU ----------------
  logic signed [2:0] m_a, m_b;
  logic [2:0]        m_op;
  logic              m_cin, m_si, m_dir, m_roa, m_rob, m_bya, m_byb;
  logic              m_inv;
  assign m_inv = ((m_roa | m_rob) & (m_op[1] | m_op[2])) | (m_op[1] & m_op[2]);

  // ALSU input registers.
  always @(posedge clk) begin
    if (rst) begin
      {m_a, m_b, m_op, m_cin, m_si, m_dir, m_roa, m_rob, m_bya, m_byb} <= '0;
    end else begin
      m_a <= alsu_A; m_b <= alsu_B; m_op <= alsu_opcode; m_cin <= alsu_cin;
      m_si <= alsu_serial_in; m_dir <= alsu_direction;
      m_roa <= alsu_red_op_A; m_rob <= alsu_red_op_B;
      m_bya <= alsu_bypass_A; m_byb <= alsu_bypass_B;
    end
  end

  // ALSU output registers.
  always @(posedge clk) begin
    if (rst) begin
      alsu_out  <= '0;
      alsu_leds <= '0;
    end else begin
      alsu_leds <= m_inv ? ~alsu_leds : 16'h0000;
      if (m_bya)      alsu_out <= m_a;
      else if (m_byb) alsu_out <= m_b;
      else if (m_inv) alsu_out <= 6'sd0;
      else begin
        case (m_op)
          3'd0: alsu_out <= m_roa ? {5'b0, |m_a} : m_rob ? {5'b0, |m_b} : m_a | m_b;
          3'd1: alsu_out <= m_roa ? {5'b0, ^m_a} : m_rob ? {5'b0, ^m_b} : m_a ^ m_b;
          3'd2: alsu_out <= m_a + m_b + $signed({1'b0, m_cin});
          3'd3: alsu_out <= m_a * m_b;
          3'd4: alsu_out <= m_dir ? {alsu_out[4:0], m_si} : {m_si, alsu_out[5:1]};
          3'd5: alsu_out <= m_dir ? {alsu_out[4:0], alsu_out[5]} : {alsu_out[0], alsu_out[5:1]};
          default: alsu_out <= 6'sd0;
        endcase
      end
    end
  end

  // ---------------- checking infrastructure ----------------
  int n_checks = 0;
  int n_pass   = 0;
  logic [3:0] exp_seq = 4'd0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
  endtask

  task automatic do_req(input logic [2:0] op, input logic signed [2:0] a, input logic signed [2:0] b,
                        input logic cin, input logic si, input logic dir, input logic roa,
                        input logic rob, input logic bya, input logic byb);
    int n;
    n = 0;
    bus.req_opcode = op; bus.req_A = a; bus.req_B = b; bus.req_cin = cin;
    bus.req_serial_in = si; bus.req_direction = dir;
    bus.req_red_op_A = roa; bus.req_red_op_B = rob;
    bus.req_bypass_A = bya; bus.req_bypass_B = byb;
    bus.req_valid = 1'b1;
    while (!bus.req_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    chk("req.ready", {31'b0, bus.req_ready}, 32'd1);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    exp_seq = exp_seq + 4'd1;
  endtask

  task automatic expect_rsp(input string tag, input logic [5:0] eo, input logic [15:0] el,
                            input logic chk_leds, input logic ei, input logic [3:0] es,
                            input int exp_lat);
    int n;
    n = 0;
    while (!bus.rsp_valid && n < 20) begin
      @(posedge clk); #1; n++;
    end
    chk({tag, ".valid"}, {31'b0, bus.rsp_valid}, 32'd1);
    if (exp_lat > 0) chk({tag, ".latency"}, n, exp_lat);
    chk({tag, ".out"}, {26'b0, $unsigned(bus.rsp_out)}, {26'b0, eo});
    if (chk_leds) chk({tag, ".leds"}, {16'b0, bus.rsp_leds}, {16'b0, el});
    chk({tag, ".invalid"}, {31'b0, bus.rsp_invalid}, {31'b0, ei});
    chk({tag, ".seq"}, {28'b0, bus.rsp_seq}, {28'b0, es});
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
  endtask

  typedef struct {
    logic [2:0]        op;
    logic signed [2:0] a, b;
    logic              cin, si, dir, roa, rob;
    logic [5:0]        exp_out;
    logic [15:0]       exp_leds;
    logic              exp_inv;
  } vec_t;

  function automatic vec_t mk(input logic [2:0] op, input logic signed [2:0] a,
                              input logic signed [2:0] b, input logic cin, input logic si,
                              input logic dir, input logic roa, input logic rob,
                              input logic [5:0] eo, input logic [15:0] el, input logic ei);
    vec_t v;
    v.op = op; v.a = a; v.b = b; v.cin = cin; v.si = si; v.dir = dir;
    v.roa = roa; v.rob = rob; v.exp_out = eo; v.exp_leds = el; v.exp_inv = ei;
    return v;
  endfunction

  vec_t       vecs [10];
  logic [3:0] s;
  logic [3:0] got [5];
  int         acc, nr;
  logic       wa, acc5, seen;

  initial begin
    bus.req_valid = 1'b0; bus.rsp_ready = 1'b0;
    bus.req_opcode = 3'd0; bus.req_A = 3'sd0; bus.req_B = 3'sd0; bus.req_cin = 1'b0;
    bus.req_serial_in = 1'b0; bus.req_direction = 1'b0; bus.req_red_op_A = 1'b0;
    bus.req_red_op_B = 1'b0; bus.req_bypass_A = 1'b0; bus.req_bypass_B = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state.
    chk("rst.rsp_valid", {31'b0, bus.rsp_valid}, 32'd0);
    chk("rst.req_ready", {31'b0, bus.req_ready}, 32'd1);
    chk("rst.rsp_fields", {5'b0, $unsigned(bus.rsp_out), bus.rsp_leds, bus.rsp_invalid, bus.rsp_seq}, 32'd0);
    chk("rst.pins", {16'b0, alsu_A, alsu_B, alsu_opcode, alsu_cin, alsu_serial_in, alsu_direction,
                     alsu_red_op_A, alsu_red_op_B, alsu_bypass_A, alsu_bypass_B}, 32'd0);

    // Single requests; entries 4 and 7 depend on the previous entry's held result.
    //            op    a      b     cin si dir roa rob  out     leds      inv
    vecs[0] = mk(3'd2,  3'sd3, 3'sd2, 1, 0, 0, 0, 0, 6'h06, 16'h0000, 0); // ADD 3+2+1
    vecs[1] = mk(3'd3, -3'sd3, 3'sd3, 0, 0, 0, 0, 0, 6'h37, 16'h0000, 0); // MULT -9
    vecs[2] = mk(3'd0,  3'sd1, 3'sd2, 0, 0, 0, 0, 0, 6'h03, 16'h0000, 0); // OR
    vecs[3] = mk(3'd1,  3'sd3, 3'sd1, 0, 0, 0, 0, 0, 6'h02, 16'h0000, 0); // XOR
    vecs[4] = mk(3'd5,  3'sd0, 3'sd0, 0, 0, 1, 0, 0, 6'h04, 16'h0000, 0); // ROTL of 2
    vecs[5] = mk(3'd2, -3'sd4,-3'sd4, 0, 0, 0, 0, 0, 6'h38, 16'h0000, 0); // ADD -8
    vecs[6] = mk(3'd0, -3'sd4, 3'sd0, 0, 0, 0, 1, 0, 6'h01, 16'h0000, 0); // |A
    vecs[7] = mk(3'd4,  3'sd0, 3'sd0, 0, 1, 0, 0, 0, 6'h20, 16'h0000, 0); // SHR in 1
    vecs[8] = mk(3'd2,  3'sd1, 3'sd1, 0, 0, 0, 0, 1, 6'h00, 16'hFFFF, 1); // red op on ADD
    vecs[9] = mk(3'd3,  3'sd2,-3'sd1, 0, 0, 0, 0, 0, 6'h3E, 16'h0000, 0); // MULT -2

    for (int i = 0; i < 10; i++) begin
      s = exp_seq;
      do_req(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].si, vecs[i].dir,
             vecs[i].roa, vecs[i].rob, 1'b0, 1'b0);
      expect_rsp($sformatf("vec%0d", i), vecs[i].exp_out, vecs[i].exp_leds, 1'b1,
                 vecs[i].exp_inv, s, 3);
    end

    // Back-to-back invalid opcode 6: leds blink FFFF then 0000.
    s = exp_seq;
    do_req(3'd6, 3'sd1, 3'sd1, 0, 0, 0, 0, 0, 0, 0);
    do_req(3'd6, 3'sd1, 3'sd1, 0, 0, 0, 0, 0, 0, 0);
    expect_rsp("b2b0", 6'h00, 16'hFFFF, 1'b1, 1'b1, s, 0);
    expect_rsp("b2b1", 6'h00, 16'h0000, 1'b1, 1'b1, 4'(s + 4'd1), 0);

    // Bypass A over invalid opcode 7.
    s = exp_seq;
    do_req(3'd7, -3'sd2, 3'sd1, 0, 0, 0, 0, 0, 1, 0);
    expect_rsp("bypass", 6'h3E, 16'h0000, 1'b0, 1'b1, s, 3);

    // Backpressure: 5 requests against a stalled consumer; seq wraps 15->0.
    s = exp_seq;
    bus.req_opcode = 3'd2; bus.req_A = 3'sd1; bus.req_B = 3'sd1; bus.req_cin = 1'b0;
    bus.req_valid = 1'b1;
    acc = 0;
    for (int c = 0; c < 10; c++) begin
      wa = bus.req_valid & bus.req_ready;
      @(posedge clk); #1;
      if (wa) acc++;
    end
    chk("bp.accepted", acc, 32'd4);
    chk("bp.req_ready_low", {31'b0, bus.req_ready}, 32'd0);
    bus.rsp_ready = 1'b1;
    nr = 0; acc5 = 1'b0;
    for (int c = 0; c < 30 && nr < 5; c++) begin
      wa = bus.req_valid & bus.req_ready;
      if (bus.rsp_valid) begin
        got[nr] = bus.rsp_seq;
        nr++;
      end
      @(posedge clk); #1;
      if (wa) begin
        bus.req_valid = 1'b0;
        acc5 = 1'b1;
      end
    end
    bus.rsp_ready = 1'b0;
    chk("bp.fifth_accepted", {31'b0, acc5}, 32'd1);
    chk("bp.rsp_count", nr, 32'd5);
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("bp.seq%0d", k), {28'b0, got[k]}, {28'b0, 4'(s + 4'(k))});
    end
    exp_seq = 4'(s + 4'd5);

    // Reset one cycle after an accept: the response is discarded.
    do_req(3'd2, 3'sd3, 3'sd2, 1, 0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrst.pins", {16'b0, alsu_A, alsu_B, alsu_opcode, alsu_cin, alsu_serial_in, alsu_direction,
                        alsu_red_op_A, alsu_red_op_B, alsu_bypass_A, alsu_bypass_B}, 32'd0);
    seen = 1'b0;
    for (int c = 0; c < 10; c++) begin
      if (bus.rsp_valid) seen = 1'b1;
      @(posedge clk); #1;
    end
    chk("midrst.no_rsp", {31'b0, seen}, 32'd0);
    exp_seq = 4'd0;
    do_req(3'd2, 3'sd1, 3'sd2, 0, 0, 0, 0, 0, 0, 0);
    expect_rsp("postrst", 6'h03, 16'h0000, 1'b1, 1'b0, 4'd0, 3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/alsu_host.md
# alsu_host

Initiator-side driver for the ALSU datapath. It accepts operation requests over a valid/ready interface and drives the ALSU input pins from registers. It captures the ALSU `out`/`leds` result at the fixed pipeline latency and returns it, tagged and in order, over a valid/ready response interface with a bounded response buffer. It sits between the test/control logic and the ALSU and owns all ALSU pin timing.

## Interface
Parameters:
- `RSP_DEPTH`, 4: response FIFO entries and maximum outstanding requests. Power of two, ≥ 4.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid` / `req_ready`  in/out  1/1  request handshake.
- `req_opcode`  in  3  ALSU opcode.
- `req_A`, `req_B`  in  3 each  signed operands.
- `req_cin`, `req_serial_in`, `req_direction`  in  1 each  operation modifiers.
- `req_red_op_A`, `req_red_op_B`, `req_bypass_A`, `req_bypass_B`  in  1 each  ALSU mode bits.
- `alsu_A`, `alsu_B`, `alsu_opcode`, `alsu_cin`, `alsu_serial_in`, `alsu_direction`, `alsu_red_op_A`, `alsu_red_op_B`, `alsu_bypass_A`, `alsu_bypass_B`  out  as req  registered ALSU pin drives.
- `alsu_out`  in  6  signed ALSU result.
- `alsu_leds`  in  16  ALSU leds.
- `rsp_valid` / `rsp_ready`  out/in  1/1  response handshake.
- `rsp_out`  out  6  captured result.
- `rsp_leds`  out  16  captured leds.
- `rsp_invalid`  out  1  predicted invalid flag.
- `rsp_seq`  out  4  request sequence number.

## Operation
- **Accept.** A request is accepted on any edge with `req_valid & req_ready`. On that edge all `alsu_*` pin registers load the request fields.
- **Idle pins.** With no accept, the pins hold their last values. Because of this, SHIFT/ROTATE keep evolving inside the ALSU while idle. A response captures only the cycle belonging to its own request.
- **In-flight tracking.** A 3-stage valid/tag shift register carries each request (its `seq` and `invalid`) from accept edge E0 to capture edge E3.
- **Capture.** At E3, `{alsu_out, alsu_leds, invalid, seq}` is pushed into the response FIFO.
- **Invalid prediction.** `invalid = ((red_op_A|red_op_B) & (opcode[1]|opcode[2])) | (opcode[1] & opcode[2])`, computed from the request fields at accept.
  - The flag is reported even when bypass overrides the ALSU result.
- **Sequence number.** `seq` is a 4-bit counter. It increments on every accept and wraps 15→0.
- **Credit rule.** `req_ready = (inflight_count + fifo_count) < RSP_DEPTH`.
  - Issue can therefore never overflow the FIFO.
  - `inflight_count` is the number of set stage-valid bits.
- **Response.** `rsp_valid = fifo not empty`. The head entry is presented and popped on `rsp_valid & rsp_ready`.
- **Simultaneous events.** Push and pop on the same edge are both performed, and the count is unchanged.
  - A pop and an accept on the same edge are both honoured. `req_ready` is evaluated from pre-edge counts: no combinational path from `rsp_ready` to `req_ready`.
- **Reset.** On `rst`, all of the following clear on the next edge, and any in-flight responses are discarded:
  - stage valids, FIFO pointers and count, `seq`;
  - all `alsu_*` pins to 0.
- **Reset values.**
  - `rsp_valid` = 0.
  - `req_ready` = 1 in the first cycle after reset.
  - `rsp_out`, `rsp_leds`, `rsp_invalid`, `rsp_seq` = 0 while the FIFO is empty.

## Timing
- **Pin timing.**
  - Pins change at E0.
  - The ALSU registers its inputs at E1 and updates `out` at E2.
  - The host samples at E3, which yields the E2 value.
- **Response latency.** `rsp_valid` rises after E3, i.e. 3 cycles from accept, provided the FIFO was empty.
- **Throughput.** One request per cycle while `rsp_ready` is high. Steady state has 3 requests in flight.
- **Ordering.** Responses are strictly in order.

## Structure
- **Package `alsu_pkg`.**
  - Opcode enum: OR=0, XOR=1, ADD=2, MULT=3, SHIFT=4, ROTATE=5; values 6 and 7 are invalid.
  - Packed request struct and response struct.
  - Constant `ALSU_LAT = 2` and derived `CAPTURE_STAGES = 3`.
- **Sub-module `alsu_rsp_fifo`.**
  - Synchronous FIFO, `RSP_DEPTH` entries, width 6+16+1+4.
  - Ports: push/pop, count, empty/full.

## Test plan
1. **ADD.** ADD with A=3, B=2, cin=1 accepted at E0 → `rsp_valid` after E3 with `rsp_out`=6, `rsp_invalid`=0, `rsp_leds`=0, `rsp_seq`=0.
2. **MULT.** MULT with A=−3, B=3 → `rsp_out`=6'h37 (−9), `rsp_invalid`=0.
3. **Back-to-back invalid.** Opcode 6, twice back-to-back → both responses have `rsp_out`=0 and `rsp_invalid`=1; `rsp_leds`=16'hFFFF, then 16'h0000.
4. **Backpressure.** Hold `rsp_ready`=0 and present 5 requests → 4 accepted, `req_ready` low after the 4th and stays low. Release → `rsp_seq` returns 0,1,2,3 in order; the 5th request is then accepted.
5. **Bypass over invalid.** `bypass_A`=1, opcode 7, A=−2 → `rsp_out`=6'h3E, `rsp_invalid`=1.
6. **Reset mid-flight.** `rst` one cycle after an accept → no `rsp_valid` ever appears for that request; next accept gets `rsp_seq`=0; all `alsu_*` pins are 0 after reset.
